keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameters: SCAN_DIV, default 50000, clk cycles each column is driven; DEBOUNCE_SCANS, default 4, consecutive agreeing full scans needed to accept a press or release.
REQ-002 clk  input  1  single system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-005 cols  output  4  keypad column drives, active-low, exactly one bit low at any time.
REQ-006 key  output  4  hex code of the accepted key.
REQ-007 key_valid  output  1  key holds an unconsumed code.
REQ-008 key_ready  input  1  consumer accepts key when high with key_valid.
REQ-009 key_held  output  1  a debounced key is currently pressed.
REQ-010 overrun  output  1  sticky flag: an accepted press was dropped.

Function
REQ-011 rows shall pass through a 2-flop synchronizer before any use.
REQ-012 The column index shall advance 0->1->2->3->0 every SCAN_DIV cycles; cols = ~(1 << index).
REQ-013 Synchronized rows shall be sampled on the last cycle of each column period into a 16-bit snapshot; bit 4*row+col set when row low.
REQ-014 A scan completes on the column-3 sample; snapshot is classified NONE (0 bits), SINGLE (1 bit, with code), or MULTI (>1 bit).
REQ-015 Code map, row 0..3 by col 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-016 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; evaluated once per completed scan, a debounce counter counts agreeing scans.
REQ-017 IDLE: SINGLE -> PRESS_WAIT with candidate = code, count = 1; NONE/MULTI -> stay.
REQ-018 PRESS_WAIT: same SINGLE increments count; reaching DEBOUNCE_SCANS -> HELD and accept candidate; NONE -> IDLE; different SINGLE restarts with new candidate, count = 1; MULTI -> IDLE.
REQ-019 HELD: NONE -> RELEASE_WAIT, count = 1; anything else stays.
REQ-020 RELEASE_WAIT: NONE increments count; reaching DEBOUNCE_SCANS -> IDLE; any other class -> HELD.
REQ-021 key_held shall be high exactly in HELD and RELEASE_WAIT.
REQ-022 Accept: if key_valid is low, or key_valid&key_ready in the same cycle, key loads the code and key_valid is high next cycle; otherwise key is unchanged and overrun sets.
REQ-023 key_valid&key_ready with no simultaneous accept clears key_valid next cycle; key shall not change while key_valid is high except per REQ-022.
REQ-024 overrun clears only on reset.
REQ-025 Latency: key_valid rises 1 cycle after the scan-complete sample that reaches DEBOUNCE_SCANS.

Reset
REQ-026 On reset: column index 0 (cols = 4'b1110), timer 0, synchronizer and snapshot 0, state IDLE, count 0, key = 0, key_valid = 0, key_held = 0, overrun = 0.
REQ-027 Reset asserted mid-scan or mid-debounce shall abandon all progress; no partial key shall appear after release.

Structure
REQ-028 Package keypad_pkg shall hold the FSM state enum, the scan-class enum, and the 16-entry code-map constant.
REQ-029 The row synchronizer shall be a sub-module sync_2ff (parameterized width); all else lives in keypad_scanner.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 2, scan = 16 cycles)
REQ-030 Hold row 1/col 2 ("6") for 5 scans, key_ready high -> key = 4'h6, key_valid high 1 cycle, key_held high until 2 NONE scans after release.
REQ-031 Press "5" for 1 scan only -> no key_valid, state returns IDLE.
REQ-032 key_ready low; press/release "1", then "2" -> key stays 4'h1, key_valid stays high, overrun = 1.
REQ-033 Press "3" and "A" together for 4 scans -> no key_valid, key_held stays 0.
REQ-034 Hold "0" with 1-scan NONE glitch while HELD -> single key_valid pulse, key_held stays high.
REQ-035 Assert reset during PRESS_WAIT for "D" -> all outputs at reset values, cols = 4'b1110, no key emitted.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, code map and scan classifier for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } scan_class_t;

   typedef struct packed {
      scan_class_t cls;
      logic [3:0]  code;
   } scan_result_t;

   // Entry 4*row+col; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
   localparam logic [15:0][3:0] KEY_CODE_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // Counts pressed switches in a full snapshot; code is meaningful only for CLS_SINGLE
   function automatic scan_result_t classify_scan(input logic [15:0] snap);
      scan_result_t res;
      logic [4:0]   hits;
      res.cls  = CLS_NONE;
      res.code = 4'h0;
      hits     = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (snap[i[3:0]]) begin
            hits     = hits + 5'd1;
            res.code = KEY_CODE_MAP[i[3:0]];
         end
      end
      if (hits == 5'd1) begin
         res.cls = CLS_SINGLE;
      end else if (hits > 5'd1) begin
         res.cls = CLS_MULTI;
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Shift the raw input through two stages to settle metastability
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Stage registers; cleared on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-deep key holding register
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);

   localparam int              TW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int              CW         = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]   COUNT_LAST = CW'(DEBOUNCE_SCANS);

   logic [3:0]    rows_sync;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    cols_q, cols_d;
   logic [15:0]   snap_q, snap_d;
   logic          sample;
   logic          scan_done;
   scan_result_t  scan_res;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic          overrun_q, overrun_d;
   logic          accept;

   sync_2ff #(.WIDTH(4)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_sync)
   );

   // Column timing and snapshot capture; classification sees the snapshot including this sample
   always_comb begin
      sample    = (timer_q == TIMER_LAST);
      scan_done = sample && (col_q == 2'd3);
      timer_d   = sample ? '0 : timer_q + 1'b1;
      col_d     = sample ? col_q + 2'd1 : col_q;
      cols_d    = ~(4'b0001 << col_d);
      snap_d    = snap_q;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            snap_d[{r[1:0], col_q}] = ~rows_sync[r];
         end
      end
      scan_res = classify_scan(snap_d);
   end

   // Scan timing registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
         col_q   <= 2'd0;
         cols_q  <= 4'b1110;
         snap_q  <= '0;
      end else begin
         timer_q <= timer_d;
         col_q   <= col_d;
         cols_q  <= cols_d;
         snap_q  <= snap_d;
      end
   end

   // Debounce transitions once per completed scan, plus key handoff to the consumer
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      cand_d      = cand_q;
      accept      = 1'b0;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;

      if (scan_done) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_res.cls == CLS_SINGLE) begin
                  state_d = ST_PRESS_WAIT;
                  cand_d  = scan_res.code;
                  count_d = CW'(1);
               end
            end
            ST_PRESS_WAIT: begin
               if (scan_res.cls == CLS_SINGLE) begin
                  if (scan_res.code == cand_q) begin
                     if ((count_q + 1'b1) >= COUNT_LAST) begin
                        state_d = ST_HELD;
                        count_d = '0;
                        accept  = 1'b1;
                     end else begin
                        count_d = count_q + 1'b1;
                     end
                  end else begin
                     cand_d  = scan_res.code;
                     count_d = CW'(1);
                  end
               end else begin
                  state_d = ST_IDLE;
                  count_d = '0;
               end
            end
            ST_HELD: begin
               if (scan_res.cls == CLS_NONE) begin
                  state_d = ST_RELEASE_WAIT;
                  count_d = CW'(1);
               end
            end
            ST_RELEASE_WAIT: begin
               if (scan_res.cls == CLS_NONE) begin
                  if ((count_q + 1'b1) >= COUNT_LAST) begin
                     state_d = ST_IDLE;
                     count_d = '0;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end else begin
                  state_d = ST_HELD;
                  count_d = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end

      // A fresh press may replace a code only when the slot is free or being drained now
      if (accept) begin
         if (!key_valid_q || key_ready) begin
            key_d       = cand_q;
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_valid_q && key_ready) begin
         key_valid_d = 1'b0;
      end

      key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
   end

   // Debounce FSM state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         cand_q      <= 4'h0;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         cand_q      <= cand_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         overrun_q   <= overrun_d;
      end
   end

   assign cols      = cols_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a scan-level reference model
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEB       = 2;
   localparam int SIG_NONE  = 100;
   localparam int SIG_MULTI = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_ready;
   logic        key_held;
   logic        overrun;
   logic [15:0] pressed;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

   // Reference model: streak of identical scan results plus the output register
   bit         m_held;
   bit         m_valid;
   bit         m_overrun;
   logic [3:0] m_key;
   int         m_sig;
   int         m_len;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed switch pulls its row low while its column is driven low
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !cols[c]) rows[r] = 1'b0;
   end

   function automatic logic [15:0] bit_of(input int idx);
      logic [15:0] v;
      v = 16'h0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_held = 0; m_valid = 0; m_overrun = 0; m_key = 4'h0; m_sig = -1; m_len = 0;
   endtask

   task automatic model_scan(input logic [15:0] pat, output bit acc, output logic [3:0] code);
      int n, idx, sig;
      n = 0; idx = 0;
      for (int i = 0; i < 16; i++) if (pat[i]) begin n++; idx = i; end
      sig  = (n == 0) ? SIG_NONE : (n == 1) ? int'(code_tab[idx]) : SIG_MULTI;
      code = (n == 1) ? code_tab[idx] : 4'h0;
      if (sig == m_sig) m_len++;
      else begin m_sig = sig; m_len = 1; end
      acc = 0;
      if (!m_held && n == 1 && m_len == DEB) begin acc = 1; m_held = 1; end
      else if (m_held && n == 0 && m_len == DEB) m_held = 0;
   endtask

   // One full 16-cycle scan with pattern pat; ready_mode 0=low 1=high 2=random
   task automatic run_scan(input logic [15:0] pat, input int ready_mode, output int vcyc);
      bit         acc;
      bit         rdy;
      logic [3:0] code;
      vcyc    = 0;
      pressed = pat;
      for (int cyc = 0; cyc < 4*SCAN_DIV; cyc++) begin
         key_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
         rdy = key_ready;
         @(posedge clk);
         acc = 0; code = 4'h0;
         if (cyc == 4*SCAN_DIV-1) model_scan(pat, acc, code);
         if (acc) begin
            if (!m_valid || rdy) begin m_key = code; m_valid = 1; end
            else m_overrun = 1;
         end else if (m_valid && rdy) m_valid = 0;
         #1;
         if (key_valid) vcyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pressed = 16'h0; key_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL reset_cols: got %b want 1110", cols); end
      n_cmp++; if (key !== 4'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0", key); end
      n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_valid_press();
      int v, total;
      logic [3:0] want_held [7] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
      total = 0;
      for (int s = 0; s < 7; s++) begin
         run_scan((s < 5) ? bit_of(6) : 16'h0, 1, v);
         total += v;
         if (s == 1) begin
            n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL six_valid: got %b want 1", key_valid); end
            n_cmp++; if (key !== 4'h6) begin n_fail++; $display("FAIL six_key: got %h want 6", key); end
         end
         n_cmp++;
         if (key_held !== want_held[s][0]) begin
            n_fail++; $display("FAIL six_held scan %0d: got %b want %b", s, key_held, want_held[s][0]);
         end
      end
      n_cmp++; if (total != 1) begin n_fail++; $display("FAIL six_pulse_cycles: got %0d want 1", total); end
      n_cmp++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL six_cols: got %b want 1110", cols); end
   endtask

   task automatic test_short_press();
      int v, total;
      total = 0;
      run_scan(bit_of(5), 1, v); total += v;
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL short_held: got %b want 0", key_held); end
      run_scan(16'h0, 1, v); total += v;
      run_scan(16'h0, 1, v); total += v;
      n_cmp++; if (total != 0) begin n_fail++; $display("FAIL short_valid_cycles: got %0d want 0", total); end
   endtask

   task automatic test_multi();
      int v, total;
      total = 0;
      for (int s = 0; s < 4; s++) begin
         run_scan(bit_of(2) | bit_of(3), 1, v); total += v;
         n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_held scan %0d: got %b want 0", s, key_held); end
      end
      run_scan(16'h0, 1, v); total += v;
      n_cmp++; if (total != 0) begin n_fail++; $display("FAIL multi_valid_cycles: got %0d want 0", total); end
   endtask

   task automatic test_glitch();
      int v, total;
      logic [15:0] seq [10];
      seq = '{bit_of(13), bit_of(13), bit_of(13), 16'h0, bit_of(13), bit_of(13), bit_of(13), 16'h0, 16'h0, 16'h0};
      total = 0;
      for (int s = 0; s < 10; s++) begin
         run_scan(seq[s], 1, v); total += v;
         if (s >= 1 && s <= 6) begin
            n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held scan %0d: got %b want 1", s, key_held); end
         end
         n_cmp++;
         if (key_held !== m_held) begin n_fail++; $display("FAIL glitch_model_held scan %0d: got %b want %b", s, key_held, m_held); end
      end
      n_cmp++; if (total != 1) begin n_fail++; $display("FAIL glitch_pulse_cycles: got %0d want 1", total); end
      n_cmp++; if (key !== 4'h0) begin n_fail++; $display("FAIL glitch_key: got %h want 0", key); end
   endtask

   task automatic test_overrun();
      int v;
      for (int s = 0; s < 12; s++)
         run_scan((s < 3) ? bit_of(0) : (s >= 6 && s < 9) ? bit_of(1) : 16'h0, 0, v);
      n_cmp++; if (key !== 4'h1) begin n_fail++; $display("FAIL ovr_key: got %h want 1", key); end
      n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", key_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      n_cmp++; if (overrun !== m_overrun) begin n_fail++; $display("FAIL ovr_model: got %b want %b", overrun, m_overrun); end
      run_scan(16'h0, 1, v);
      n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b want 0", key_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_reset_mid_debounce();
      int v, total;
      run_scan(bit_of(15), 1, v);
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL mid_prewait_held: got %b want 0", key_held); end
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_cmp++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL mid_cols: got %b want 1110", cols); end
      n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", key_valid); end
      n_cmp++; if (key !== 4'h0) begin n_fail++; $display("FAIL mid_key: got %h want 0", key); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b want 0", overrun); end
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL mid_held: got %b want 0", key_held); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      total = 0;
      run_scan(bit_of(15), 1, v); total += v;
      run_scan(16'h0, 1, v); total += v;
      run_scan(16'h0, 1, v); total += v;
      n_cmp++; if (total != 0) begin n_fail++; $display("FAIL mid_no_key: got %0d valid cycles want 0", total); end
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL mid_after_held: got %b want 0", key_held); end
   endtask

   task automatic test_random();
      int v;
      int r;
      int idx;
      logic [15:0] pat;
      pat = 16'h0;
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 2) == 0) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            if (r < 4) pat = 16'h0;
            else if (r < 9) pat = bit_of(idx);
            else pat = bit_of(idx) | bit_of((idx + 5) % 16);
         end
         run_scan(pat, 2, v);
         n_cmp++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid scan %0d: got %b want %b", s, key_valid, m_valid); end
         n_cmp++; if (key !== m_key) begin n_fail++; $display("FAIL rnd_key scan %0d: got %h want %h", s, key, m_key); end
         n_cmp++; if (key_held !== m_held) begin n_fail++; $display("FAIL rnd_held scan %0d: got %b want %b", s, key_held, m_held); end
         n_cmp++; if (overrun !== m_overrun) begin n_fail++; $display("FAIL rnd_overrun scan %0d: got %b want %b", s, overrun, m_overrun); end
         n_cmp++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL rnd_cols scan %0d: got %b want 1110", s, cols); end
      end
   endtask

   initial begin
      test_reset();
      test_valid_press();
      test_short_press();
      test_multi();
      test_glitch();
      test_overrun();
      test_reset_mid_debounce();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
